// File: rtl/pac_game_pkg.sv
// Shared definitions for the coin game controller: state encoding,
// default geometry/game parameters and a tile-coordinate helper.
package pac_game_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_DEATH = 3'd2,
        ST_CLEAR = 3'd3,
        ST_OVER  = 3'd4
    } game_state_t;

    localparam int DEF_MAP_W        = 48;
    localparam int DEF_MAP_H        = 27;
    localparam int DEF_TILE_PX      = 40;
    localparam int DEF_N_ENEMY      = 4;
    localparam int DEF_LIVES        = 3;
    localparam int DEF_SCORE_W      = 16;
    localparam int DEF_COIN_CODE    = 2;
    localparam int DEF_COIN_PTS     = 10;
    localparam int DEF_DEATH_FRAMES = 60;
    localparam int DEF_CLEAR_FRAMES = 120;

    localparam int ADDR_W  = 11;
    localparam int POS_W   = 12;
    localparam int FRAME_W = 16;

    // Tile index along one axis for a sprite whose top-left pixel is pos:
    // the sprite centre (pos + half a tile) divided by the tile edge.
    function automatic logic [12:0] tile_coord(input logic [11:0] pos, input int tile_px);
        logic [12:0] centre;
        centre = {1'b0, pos} + 13'(tile_px / 2);
        return centre / 13'(tile_px);
    endfunction

endpackage

// File: rtl/pac_overlap.sv
// Purely combinational overlap test of two TILE_PX x TILE_PX squares given
// their top-left corners. Sums are 13 bits wide so they never wrap.
module pac_overlap
    import pac_game_pkg::*;
#(
    parameter int TILE_PX = DEF_TILE_PX
) (
    input  logic [11:0] a_x,
    input  logic [11:0] a_y,
    input  logic [11:0] b_x,
    input  logic [11:0] b_y,
    output logic        hit
);

    localparam logic [12:0] EDGE = 13'(TILE_PX);

    logic [12:0] ax;
    logic [12:0] ay;
    logic [12:0] bx;
    logic [12:0] by;

    assign ax = {1'b0, a_x};
    assign ay = {1'b0, a_y};
    assign bx = {1'b0, b_x};
    assign by = {1'b0, b_y};

    // Strict inequalities: squares that merely touch do not collide.
    assign hit = (ax < bx + EDGE) && (bx < ax + EDGE) &&
                 (ay < by + EDGE) && (by < ay + EDGE);

endmodule

// File: rtl/coin_game_ctrl.sv
// Game controller: loads the coin map from the tile ROM, lets Pac-Man eat
// coins, detects enemy collisions and sequences death / level-clear /
// game-over phases on frame ticks.
module coin_game_ctrl
    import pac_game_pkg::*;
#(
    parameter int MAP_W        = DEF_MAP_W,
    parameter int MAP_H        = DEF_MAP_H,
    parameter int TILE_PX      = DEF_TILE_PX,
    parameter int N_ENEMY      = DEF_N_ENEMY,
    parameter int LIVES        = DEF_LIVES,
    parameter int SCORE_W      = DEF_SCORE_W,
    parameter int COIN_CODE    = DEF_COIN_CODE,
    parameter int COIN_PTS     = DEF_COIN_PTS,
    parameter int DEATH_FRAMES = DEF_DEATH_FRAMES,
    parameter int CLEAR_FRAMES = DEF_CLEAR_FRAMES
) (
    input  logic                   clk_pix,
    input  logic                   reset,
    input  logic                   frame_tick,
    input  logic                   start,
    output logic [10:0]            rom_addr,
    input  logic [3:0]             rom_code,
    input  logic [11:0]            pac_x,
    input  logic [11:0]            pac_y,
    input  logic [N_ENEMY*12-1:0]  enemy_x,
    input  logic [N_ENEMY*12-1:0]  enemy_y,
    input  logic [10:0]            disp_addr,
    output logic                   coin_at_disp,
    output logic [SCORE_W-1:0]     score,
    output logic [10:0]            coins_left,
    output logic [1:0]             lives,
    output logic [2:0]             state,
    output logic                   game_reset,
    output logic                   level_clear
);

    localparam int               COIN_CNT   = MAP_W * MAP_H;
    localparam logic [10:0]      CNT_A      = 11'(COIN_CNT);
    localparam logic [10:0]      LAST_ADDR  = 11'(COIN_CNT - 1);
    localparam logic [12:0]      MAP_W13    = 13'(MAP_W);
    localparam logic [12:0]      MAP_H13    = 13'(MAP_H);
    localparam logic [FRAME_W-1:0] DEATH_LAST = FRAME_W'(DEATH_FRAMES - 1);
    localparam logic [FRAME_W-1:0] CLEAR_LAST = FRAME_W'(CLEAR_FRAMES - 1);
    localparam logic [SCORE_W:0] PTS_W      = (SCORE_W + 1)'(COIN_PTS);
    localparam logic [1:0]       LIVES_INIT = 2'(LIVES);

    // One coin bit per tile.
    logic coin_mem [0:COIN_CNT-1];

    game_state_t        state_reg,       state_next;
    logic [10:0]        addr_reg,        addr_next;
    logic               wr_valid_reg,    wr_valid_next;
    logic [10:0]        wr_addr_reg,     wr_addr_next;
    logic [10:0]        fill_reg,        fill_next;
    logic [10:0]        coins_reg,       coins_next;
    logic [SCORE_W-1:0] score_reg,       score_next;
    logic [1:0]         lives_reg,       lives_next;
    logic [FRAME_W-1:0] frame_cnt_reg,   frame_cnt_next;
    logic               game_reset_reg,  game_reset_next;
    logic               level_clear_reg, level_clear_next;
    logic               coin_at_disp_reg;

    logic               mem_we;
    logic [10:0]        mem_waddr;
    logic               mem_wdata;

    logic [N_ENEMY-1:0] hit_vec;
    logic               any_hit;
    logic [12:0]        tile_x;
    logic [12:0]        tile_y;
    logic               in_map;
    logic [10:0]        tile_idx;
    logic               eat;
    logic               rom_is_coin;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_add;

    genvar gi;
    generate
        for (gi = 0; gi < N_ENEMY; gi++) begin : g_enemy
            pac_overlap #(
                .TILE_PX (TILE_PX)
            ) u_overlap (
                .a_x (pac_x),
                .a_y (pac_y),
                .b_x (enemy_x[12*gi +: 12]),
                .b_y (enemy_y[12*gi +: 12]),
                .hit (hit_vec[gi])
            );
        end
    endgenerate

    assign any_hit = |hit_vec;

    // Tile under the sprite centre; the coin lookup is asynchronous so an
    // eat lands on the very next edge.
    assign tile_x   = tile_coord(pac_x, TILE_PX);
    assign tile_y   = tile_coord(pac_y, TILE_PX);
    assign in_map   = (tile_x < MAP_W13) && (tile_y < MAP_H13);
    assign tile_idx = 11'(tile_y) * 11'(MAP_W) + 11'(tile_x);
    assign eat      = (state_reg == ST_PLAY) && in_map && coin_mem[tile_idx];

    assign rom_is_coin = (rom_code == 4'(COIN_CODE));
    assign score_sum   = {1'b0, score_reg} + PTS_W;
    assign score_add   = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

    // Next-state and datapath control for the game sequencer.
    always_comb begin
        state_next       = state_reg;
        addr_next        = addr_reg;
        wr_valid_next    = 1'b0;
        wr_addr_next     = wr_addr_reg;
        fill_next        = fill_reg;
        coins_next       = coins_reg;
        score_next       = score_reg;
        lives_next       = lives_reg;
        frame_cnt_next   = frame_cnt_reg;
        game_reset_next  = 1'b0;
        level_clear_next = 1'b0;
        mem_we           = 1'b0;
        mem_waddr        = wr_addr_reg;
        mem_wdata        = 1'b0;

        case (state_reg)
            ST_INIT: begin
                // Issue one ROM address per cycle; the data returns a cycle
                // later and is written at the address remembered in wr_addr.
                if (addr_reg < CNT_A) begin
                    addr_next     = addr_reg + 11'd1;
                    wr_valid_next = 1'b1;
                    wr_addr_next  = addr_reg;
                end
                if (wr_valid_reg) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_addr_reg;
                    mem_wdata = rom_is_coin;
                    fill_next = fill_reg + 11'd1;
                    if (rom_is_coin) begin
                        coins_next = coins_reg + 11'd1;
                    end
                    if (wr_addr_reg == LAST_ADDR) begin
                        state_next = (coins_next == 11'd0) ? ST_CLEAR : ST_PLAY;
                    end
                end
            end

            ST_PLAY: begin
                if (eat) begin
                    mem_we     = 1'b1;
                    mem_waddr  = tile_idx;
                    mem_wdata  = 1'b0;
                    coins_next = coins_reg - 11'd1;
                    score_next = score_add;
                end
                // Clearing the level outranks a simultaneous collision.
                if ((coins_reg == 11'd0) || (eat && (coins_reg == 11'd1))) begin
                    state_next       = ST_CLEAR;
                    level_clear_next = 1'b1;
                    frame_cnt_next   = '0;
                end else if (frame_tick && any_hit) begin
                    state_next      = ST_DEATH;
                    lives_next      = (lives_reg != 2'd0) ? lives_reg - 2'd1 : 2'd0;
                    game_reset_next = 1'b1;
                    frame_cnt_next  = '0;
                end
            end

            ST_DEATH: begin
                if (frame_tick) begin
                    if (frame_cnt_reg == DEATH_LAST) begin
                        frame_cnt_next = '0;
                        state_next     = (lives_reg != 2'd0) ? ST_PLAY : ST_OVER;
                    end else begin
                        frame_cnt_next = frame_cnt_reg + FRAME_W'(1);
                    end
                end
            end

            ST_CLEAR: begin
                if (frame_tick) begin
                    if (frame_cnt_reg == CLEAR_LAST) begin
                        state_next     = ST_INIT;
                        addr_next      = '0;
                        fill_next      = '0;
                        coins_next     = '0;
                        frame_cnt_next = '0;
                    end else begin
                        frame_cnt_next = frame_cnt_reg + FRAME_W'(1);
                    end
                end
            end

            ST_OVER: begin
                if (start) begin
                    state_next     = ST_INIT;
                    addr_next      = '0;
                    fill_next      = '0;
                    coins_next     = '0;
                    frame_cnt_next = '0;
                    score_next     = '0;
                    lives_next     = LIVES_INIT;
                end
            end

            default: begin
                state_next     = ST_INIT;
                addr_next      = '0;
                fill_next      = '0;
                coins_next     = '0;
                frame_cnt_next = '0;
            end
        endcase
    end

    // Sequencer and counter registers.
    always_ff @(posedge clk_pix) begin
        if (reset) begin
            state_reg       <= ST_INIT;
            addr_reg        <= '0;
            wr_valid_reg    <= 1'b0;
            wr_addr_reg     <= '0;
            fill_reg        <= '0;
            coins_reg       <= '0;
            score_reg       <= '0;
            lives_reg       <= LIVES_INIT;
            frame_cnt_reg   <= '0;
            game_reset_reg  <= 1'b0;
            level_clear_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            wr_valid_reg    <= wr_valid_next;
            wr_addr_reg     <= wr_addr_next;
            fill_reg        <= fill_next;
            coins_reg       <= coins_next;
            score_reg       <= score_next;
            lives_reg       <= lives_next;
            frame_cnt_reg   <= frame_cnt_next;
            game_reset_reg  <= game_reset_next;
            level_clear_reg <= level_clear_next;
        end
    end

    // Coin map write port (sweep fill or eat clear, never both at once).
    always_ff @(posedge clk_pix) begin
        if (mem_we) begin
            coin_mem[mem_waddr] <= mem_wdata;
        end
    end

    // Display read port; bits beyond the fill point of the current sweep
    // (or beyond the map) read as empty, which also hides stale contents.
    always_ff @(posedge clk_pix) begin
        if (reset) begin
            coin_at_disp_reg <= 1'b0;
        end else if (disp_addr < fill_reg) begin
            coin_at_disp_reg <= coin_mem[disp_addr];
        end else begin
            coin_at_disp_reg <= 1'b0;
        end
    end

    assign rom_addr     = addr_reg;
    assign coin_at_disp = coin_at_disp_reg;
    assign score        = score_reg;
    assign coins_left   = coins_reg;
    assign lives        = lives_reg;
    assign state        = state_reg;
    assign game_reset   = game_reset_reg;
    assign level_clear  = level_clear_reg;

endmodule

// File: tb/tb_coin_game_ctrl.sv
// Bench for coin_game_ctrl: directed game scenarios plus randomized eating
// and collision trials, checked against a tile-level game model.
module tb_coin_game_ctrl;
    import pac_game_pkg::*;

    localparam int MW  = 48;
    localparam int MH  = 27;
    localparam int TP  = 40;
    localparam int NE  = 4;
    localparam int CNT = MW * MH;
    localparam int DF  = 60;
    localparam int CF  = 120;
    localparam int PTS = 10;

    logic              clk_pix = 1'b0;
    logic              reset = 1'b1;
    logic              frame_tick = 1'b0;
    logic              start = 1'b0;
    logic [10:0]       rom_addr;
    logic [3:0]        rom_code;
    logic [11:0]       pac_x;
    logic [11:0]       pac_y;
    logic [NE*12-1:0]  enemy_x;
    logic [NE*12-1:0]  enemy_y;
    logic [10:0]       disp_addr;
    logic              coin_at_disp;
    logic [15:0]       score;
    logic [10:0]       coins_left;
    logic [1:0]        lives;
    logic [2:0]        state;
    logic              game_reset;
    logic              level_clear;

    logic [3:0] rom_mem [0:2047];

    int checks_cnt = 0;
    int errors_cnt = 0;

    // Reference model: which tiles hold coins, plus game counters.
    bit model_coin [0:CNT-1];
    int m_score;
    int m_lives;
    int m_coins;

    coin_game_ctrl dut (
        .clk_pix      (clk_pix),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .start        (start),
        .rom_addr     (rom_addr),
        .rom_code     (rom_code),
        .pac_x        (pac_x),
        .pac_y        (pac_y),
        .enemy_x      (enemy_x),
        .enemy_y      (enemy_y),
        .disp_addr    (disp_addr),
        .coin_at_disp (coin_at_disp),
        .score        (score),
        .coins_left   (coins_left),
        .lives        (lives),
        .state        (state),
        .game_reset   (game_reset),
        .level_clear  (level_clear)
    );

    always #5 clk_pix = ~clk_pix;

    // Tile ROM with one-cycle read latency.
    always @(posedge clk_pix) rom_code <= rom_mem[rom_addr];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic read_disp(input int a, output logic v);
        disp_addr = 11'(a);
        step();
        v = coin_at_disp;
    endtask

    task automatic set_pac(input int x, input int y);
        pac_x = 12'(x);
        pac_y = 12'(y);
    endtask

    task automatic set_enemy(input int ch, input int x, input int y);
        enemy_x[12*ch +: 12] = 12'(x);
        enemy_y[12*ch +: 12] = 12'(y);
    endtask

    task automatic park_enemies();
        for (int i = 0; i < NE; i++) set_enemy(i, 3000, 3000);
    endtask

    task automatic wait_state(input int target, input int budget, output int n);
        n = 0;
        while (state !== 3'(target) && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic run_death(input int exp_after);
        repeat (DF - 1) tick();
        check_val("death_hold", state, ST_DEATH);
        tick();
        check_val("death_exit", state, exp_after);
    endtask

    function automatic logic [3:0] noncoin();
        int r;
        r = $urandom_range(0, 14);
        return (r >= 2) ? 4'(r + 1) : 4'(r);
    endfunction

    function automatic int tile_of(input int p);
        return (p + TP / 2) / TP;
    endfunction

    function automatic bit overlap(input int ax, input int ay, input int bx, input int by);
        int dx;
        int dy;
        dx = (ax > bx) ? ax - bx : bx - ax;
        dy = (ay > by) ? ay - by : by - ay;
        return (dx < TP) && (dy < TP);
    endfunction

    task automatic load_model();
        m_coins = 0;
        for (int a = 0; a < CNT; a++) begin
            model_coin[a] = (rom_mem[a] == 4'd2);
            if (model_coin[a]) m_coins++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_state"}, state, ST_INIT);
        check_val({tag, "_rom_addr"}, rom_addr, 0);
        check_val({tag, "_score"}, score, 0);
        check_val({tag, "_lives"}, lives, 3);
        check_val({tag, "_coins"}, coins_left, 0);
        check_val({tag, "_game_reset"}, game_reset, 0);
        check_val({tag, "_level_clear"}, level_clear, 0);
        check_val({tag, "_coin_at_disp"}, coin_at_disp, 0);
    endtask

    initial begin
        int   n;
        int   n2;
        int   orig_coins;
        int   last_a;
        int   px;
        int   py;
        int   tx;
        int   ty;
        int   idx;
        bit   hit;
        bit   inm;
        logic v;
        int   ex [NE];
        int   ey [NE];

        for (int a = 0; a < 2048; a++) rom_mem[a] = noncoin();
        rom_mem[5]    = 4'd2;
        rom_mem[1295] = 4'd2;
        set_pac(4000, 4000);
        park_enemies();
        disp_addr = 11'd5;

        // Reset state
        repeat (3) step();
        check_reset_vals("reset");

        // Reset in the middle of the sweep
        reset = 1'b0;
        n = 0;
        while (rom_addr !== 11'd600 && n < 1000) begin
            step();
            n++;
        end
        check_val("sweep_reaches_600", rom_addr, 600);
        check_val("mid_sweep_disp5", coin_at_disp, 1);
        check_val("mid_sweep_coins", coins_left, 1);
        reset = 1'b1;
        step();
        check_reset_vals("midsweep_reset");
        reset = 1'b0;

        // Full sweep timing and contents
        wait_state(ST_PLAY, 2000, n);
        check_val("init_to_play_cycles", n, 1297);
        check_val("coins_after_sweep", coins_left, 2);
        read_disp(5, v);    check_val("disp_5", v, 1);
        read_disp(6, v);    check_val("disp_6", v, 0);
        read_disp(1295, v); check_val("disp_1295", v, 1);
        read_disp(1500, v); check_val("disp_off_map", v, 0);
        load_model();
        m_score = 0;
        m_lives = 3;

        // Eat the coin on tile 5, then loiter there
        set_pac(200, 0);
        step();
        step();
        model_coin[5] = 1'b0;
        m_coins--;
        m_score += PTS;
        check_val("eat5_score", score, m_score);
        check_val("eat5_coins", coins_left, m_coins);
        read_disp(5, v);
        check_val("eat5_disp", v, 0);
        repeat (10) tick();
        check_val("loiter_score", score, m_score);

        // start is ignored outside OVER
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("start_in_play_state", state, ST_PLAY);
        check_val("start_in_play_score", score, m_score);

        // Enemy 2 just overlapping on the same row
        set_enemy(2, 239, 0);
        tick();
        m_lives--;
        check_val("hit_game_reset", game_reset, 1);
        check_val("hit_lives", lives, m_lives);
        check_val("hit_state", state, ST_DEATH);
        step();
        check_val("hit_game_reset_drop", game_reset, 0);
        park_enemies();
        run_death(ST_PLAY);

        // Randomized collision trials until the lives run out
        set_pac(400, 400);
        for (int t = 0; t < 40 && m_lives > 0; t++) begin
            ex[0] = 400 + $urandom_range(0, 120) - 60;
            ey[0] = 400 + $urandom_range(0, 120) - 60;
            for (int i = 1; i < NE; i++) begin
                ex[i] = $urandom_range(0, 4095);
                ey[i] = $urandom_range(0, 4095);
            end
            hit = 1'b0;
            for (int i = 0; i < NE; i++) begin
                set_enemy(i, ex[i], ey[i]);
                if (overlap(400, 400, ex[i], ey[i])) hit = 1'b1;
            end
            tick();
            $display("collide trial %0d e0=(%0d,%0d) hit=%0d lives=%0d", t, ex[0], ey[0], hit, lives);
            park_enemies();
            if (hit) begin
                m_lives--;
                check_val("rand_hit_state", state, ST_DEATH);
                check_val("rand_hit_lives", lives, m_lives);
                run_death(m_lives > 0 ? ST_PLAY : ST_OVER);
            end else begin
                check_val("rand_miss_state", state, ST_PLAY);
                check_val("rand_miss_lives", lives, m_lives);
            end
        end
        while (m_lives > 0) begin
            set_enemy(0, 400, 400);
            tick();
            park_enemies();
            m_lives--;
            check_val("forced_hit_lives", lives, m_lives);
            run_death(m_lives > 0 ? ST_PLAY : ST_OVER);
        end

        // Game over holds until start
        check_val("over_state", state, ST_OVER);
        check_val("over_lives", lives, 0);
        repeat (5) tick();
        check_val("over_hold_state", state, ST_OVER);
        check_val("over_hold_score", score, m_score);

        // New random maze, restart
        for (int a = 0; a < 2048; a++)
            rom_mem[a] = ($urandom_range(0, 7) == 0) ? 4'd2 : noncoin();
        rom_mem[7]    = 4'd2;
        rom_mem[1000] = 4'd2;
        load_model();
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("restart_state", state, ST_INIT);
        check_val("restart_score", score, 0);
        check_val("restart_lives", lives, 3);
        check_val("restart_coins", coins_left, 0);
        repeat (200) step();
        read_disp(1295, v);
        check_val("unswept_reads_zero", v, 0);
        wait_state(ST_PLAY, 2000, n2);
        check_val("restart_sweep_cycles", 201 + n2, 1297);
        m_score = 0;
        m_lives = 3;
        orig_coins = m_coins;
        check_val("restart_coins_loaded", coins_left, m_coins);
        for (int k = 0; k < 8; k++) begin
            idx = $urandom_range(0, CNT - 1);
            read_disp(idx, v);
            check_val("rand_disp", v, model_coin[idx]);
        end

        // Randomized pac positions, some off the map
        for (int t = 0; t < 40; t++) begin
            px  = $urandom_range(0, 1990);
            py  = $urandom_range(0, 1150);
            tx  = tile_of(px);
            ty  = tile_of(py);
            inm = (tx < MW) && (ty < MH);
            idx = ty * MW + tx;
            if (inm && model_coin[idx] && m_coins == 1) begin
                px  = 4000;
                inm = 1'b0;
            end
            set_pac(px, py);
            step();
            step();
            if (inm && model_coin[idx]) begin
                model_coin[idx] = 1'b0;
                m_coins--;
                m_score += PTS;
            end
            $display("eat trial %0d pac=(%0d,%0d) in_map=%0d score=%0d coins=%0d", t, px, py, inm, score, coins_left);
            check_val("rand_eat_score", score, m_score);
            check_val("rand_eat_coins", coins_left, m_coins);
            if (inm) begin
                read_disp(idx, v);
                check_val("rand_eat_disp", v, 0);
            end
        end

        // Eat everything but one coin
        last_a = -1;
        for (int a = 0; a < CNT; a++) begin
            if (model_coin[a]) begin
                if (m_coins > 1) begin
                    set_pac((a % MW) * TP, (a / MW) * TP);
                    step();
                    step();
                    model_coin[a] = 1'b0;
                    m_coins--;
                    m_score += PTS;
                end else begin
                    last_a = a;
                end
            end
        end
        check_val("one_left_coins", coins_left, 1);
        check_val("one_left_score", score, m_score);

        // Last coin and a collision on the same frame tick
        px = (last_a % MW) * TP;
        py = (last_a / MW) * TP;
        set_pac(px, py);
        set_enemy(0, px, py);
        tick();
        m_score += PTS;
        check_val("clear_pulse", level_clear, 1);
        check_val("clear_state", state, ST_CLEAR);
        check_val("clear_lives", lives, m_lives);
        check_val("clear_no_game_reset", game_reset, 0);
        check_val("clear_coins", coins_left, 0);
        check_val("clear_score", score, m_score);
        set_pac(4000, 4000);
        park_enemies();
        step();
        check_val("clear_pulse_drop", level_clear, 0);
        repeat (CF - 1) tick();
        check_val("clear_hold", state, ST_CLEAR);
        tick();
        check_val("clear_exit", state, ST_INIT);
        wait_state(ST_PLAY, 2000, n);
        check_val("resweep_cycles", n, 1297);
        load_model();
        check_val("resweep_coins", coins_left, orig_coins);
        check_val("resweep_score", score, m_score);
        check_val("resweep_lives", lives, m_lives);
        read_disp(1000, v);
        check_val("resweep_disp_1000", v, 1);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
